// File: rtl/mpu_imul_sequencer_if.sv
// Command and result handshake bundle for the IMUL sequencer.
// The master drives commands and accepts results; the slave is the sequencer.
interface mpu_imul_sequencer_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [199:0] matrix_a;
  logic [7:0]   factor;
  logic [199:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         busy;
  logic         overflow;

  modport master (
    output cmd_valid, matrix_a, factor, result_ready,
    input  cmd_ready, result, result_valid, busy, overflow
  );

  modport slave (
    input  cmd_valid, matrix_a, factor, result_ready,
    output cmd_ready, result, result_valid, busy, overflow
  );
endinterface

// File: rtl/mpu_imul_sequencer.sv
// Time-multiplexed scalar multiply of a signed 5x5 byte matrix over LANES shared multipliers.
// Define MPU_IMUL_SATURATE_EN to clamp lane results instead of two's-complement wrapping.
module mpu_imul_sequencer #(
  parameter int LANES = 1
) (
  input logic                 clk,
  input logic                 reset,
  mpu_imul_sequencer_if.slave bus
);

  if (LANES != 1 && LANES != 5 && LANES != 25) begin : g_bad_lanes
    $error("mpu_imul_sequencer: LANES must be 1, 5 or 25");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [199:0]   a_q, a_d;
  logic [7:0]     factor_q, factor_d;
  logic [199:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic signed [15:0] prod_s [LANES];

  function automatic logic lane_ovf(input logic signed [15:0] p);
    return (p > 16'sd127) || (p < -16'sd128);
  endfunction

  function automatic logic [7:0] lane_result(input logic signed [15:0] p);
`ifdef MPU_IMUL_SATURATE_EN
    if (p > 16'sd127) begin
      return 8'h7F;
    end else if (p < -16'sd128) begin
      return 8'h80;
    end else begin
      return p[7:0];
    end
`else
    return p[7:0];
`endif
  endfunction

  // Exact products for the element group currently addressed by idx_q
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      prod_s[j] = 16'($signed(factor_q)) * 16'($signed(a_q[8*(int'(idx_q)+j) +: 8]));
    end
  end

  // Next-state, datapath update and registered output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    factor_d = factor_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          a_d      = bus.matrix_a;
          factor_d = bus.factor;
          result_d = 200'd0;
          ovf_d    = 1'b0;
          idx_d    = 5'd0;
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        for (int j = 0; j < LANES; j++) begin
          result_d[8*(int'(idx_q)+j) +: 8] = lane_result(prod_s[j]);
          ovf_d = ovf_d | lane_ovf(prod_s[j]);
        end
        // idx parks on the last group rather than running past element 24
        if (int'(idx_q) + LANES == 25) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 5'(LANES);
        end
      end
      S_DONE: begin
        if (bus.result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    valid_d     = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 5'd0;
      a_q         <= 200'd0;
      factor_q    <= 8'd0;
      result_q    <= 200'd0;
      ovf_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      factor_q    <= factor_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_mpu_imul_sequencer.sv
// Bench for mpu_imul_sequencer: LANES = 1, 5 and 25 instances share one stimulus stream
// and are each checked every cycle against a cycle-level arithmetic model.
module tb_mpu_imul_sequencer;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         cmd_valid;
  logic         result_ready;
  logic [199:0] matrix_a;
  logic [7:0]   factor;

  logic         o_ready [NI];
  logic         o_busy  [NI];
  logic         o_rv    [NI];
  logic         o_ovf   [NI];
  logic [199:0] o_res   [NI];

  mpu_imul_sequencer_if bus_l1 ();
  mpu_imul_sequencer_if bus_l5 ();
  mpu_imul_sequencer_if bus_l25 ();

  assign bus_l1.cmd_valid     = cmd_valid;
  assign bus_l1.matrix_a      = matrix_a;
  assign bus_l1.factor        = factor;
  assign bus_l1.result_ready  = result_ready;
  assign bus_l5.cmd_valid     = cmd_valid;
  assign bus_l5.matrix_a      = matrix_a;
  assign bus_l5.factor        = factor;
  assign bus_l5.result_ready  = result_ready;
  assign bus_l25.cmd_valid    = cmd_valid;
  assign bus_l25.matrix_a     = matrix_a;
  assign bus_l25.factor       = factor;
  assign bus_l25.result_ready = result_ready;

  assign o_ready[0] = bus_l1.cmd_ready;
  assign o_busy[0]  = bus_l1.busy;
  assign o_rv[0]    = bus_l1.result_valid;
  assign o_ovf[0]   = bus_l1.overflow;
  assign o_res[0]   = bus_l1.result;
  assign o_ready[1] = bus_l5.cmd_ready;
  assign o_busy[1]  = bus_l5.busy;
  assign o_rv[1]    = bus_l5.result_valid;
  assign o_ovf[1]   = bus_l5.overflow;
  assign o_res[1]   = bus_l5.result;
  assign o_ready[2] = bus_l25.cmd_ready;
  assign o_busy[2]  = bus_l25.busy;
  assign o_rv[2]    = bus_l25.result_valid;
  assign o_ovf[2]   = bus_l25.overflow;
  assign o_res[2]   = bus_l25.result;

  mpu_imul_sequencer #(.LANES(1))  u_dut_l1  (.clk(clk), .reset(reset), .bus(bus_l1));
  mpu_imul_sequencer #(.LANES(5))  u_dut_l5  (.clk(clk), .reset(reset), .bus(bus_l5));
  mpu_imul_sequencer #(.LANES(25)) u_dut_l25 (.clk(clk), .reset(reset), .bus(bus_l25));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic int lanes_of(input int i);
    if (i == 0) return 1;
    else if (i == 1) return 5;
    else return 25;
  endfunction

  function automatic int prod(input logic [199:0] a, input logic [7:0] f, input int k);
    return int'($signed(a[8*k +: 8])) * int'($signed(f));
  endfunction

  function automatic logic [7:0] elem_of(input int p);
`ifdef MPU_IMUL_SATURATE_EN
    if (p > 127) return 8'h7F;
    if (p < -128) return 8'h80;
`endif
    return p[7:0];
  endfunction

  function automatic logic [199:0] seq_mat(input int start, input int step);
    logic [199:0] m;
    int v;
    for (int k = 0; k < 25; k++) begin
      v = start + step * k;
      m[8*k +: 8] = v[7:0];
    end
    return m;
  endfunction

  function automatic logic [199:0] rand_mat();
    logic [199:0] m;
    for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'($urandom);
    return m;
  endfunction

  // Model: phase per instance (0 idle, 1 run, 2 done) and number of elements written so far
  int         m_st [NI];
  int         m_wr [NI];
  logic [7:0] m_elem [NI][25];
  bit         m_ov   [NI][25];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_st[i] <= 0;
        m_wr[i] <= 0;
      end else if (m_st[i] == 0) begin
        if (cmd_valid) begin
          for (int k = 0; k < 25; k++) begin
            m_elem[i][k] <= elem_of(prod(matrix_a, factor, k));
            m_ov[i][k]   <= (prod(matrix_a, factor, k) > 127) || (prod(matrix_a, factor, k) < -128);
          end
          m_wr[i] <= 0;
          m_st[i] <= 1;
        end
      end else if (m_st[i] == 1) begin
        m_wr[i] <= m_wr[i] + lanes_of(i);
        if (m_wr[i] + lanes_of(i) >= 25) m_st[i] <= 2;
      end else if (result_ready) begin
        m_st[i] <= 0;
      end
    end
  end

  function automatic logic [199:0] exp_result(input int i);
    logic [199:0] r;
    r = '0;
    for (int k = 0; k < 25; k++) if (k < m_wr[i]) r[8*k +: 8] = m_elem[i][k];
    return r;
  endfunction

  function automatic logic exp_ovf(input int i);
    logic o;
    o = 1'b0;
    for (int k = 0; k < 25; k++) if (k < m_wr[i]) o = o | m_ov[i][k];
    return o;
  endfunction

  task automatic chk(input string nm, input int i, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [LANES=%0d] @%0t: got %h, want %h", nm, lanes_of(i), $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("cmd_ready", i, 200'(o_ready[i]), 200'(m_st[i] == 0));
        chk("busy", i, 200'(o_busy[i]), 200'(m_st[i] != 0));
        chk("result_valid", i, 200'(o_rv[i]), 200'(m_st[i] == 2));
        chk("result", i, o_res[i], exp_result(i));
        chk("overflow", i, 200'(o_ovf[i]), 200'(exp_ovf(i)));
      end
    end
  end

  task automatic issue(input logic [199:0] a, input logic [7:0] f);
    matrix_a  = a;
    factor    = f;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Called right after issue: counts edges after accept until result_valid per instance
  task automatic measure(input bit scramble, output logic [199:0] r0, output logic ov0);
    int lat [NI];
    lat = '{-1, -1, -1};
    r0  = '0;
    ov0 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (o_rv[i] && lat[i] < 0) begin
          lat[i] = c;
          if (i == 0) begin
            r0  = o_res[0];
            ov0 = o_ovf[0];
          end
        end
      end
      if (lat[0] >= 0) break;
      if (scramble) begin
        matrix_a = rand_mat();
        factor   = 8'($urandom);
      end
      @(negedge clk);
    end
    chk("latency", 0, 200'(lat[0]), 200'(25));
    chk("latency", 1, 200'(lat[1]), 200'(5));
    chk("latency", 2, 200'(lat[2]), 200'(1));
    @(negedge clk);
  endtask

  logic [199:0] r0, a, cap;
  logic         ov0, capov;
  int           cnt [NI];

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; result_ready = 1'b1; matrix_a = '0; factor = '0;
    @(posedge clk);
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", i, 200'(o_ready[i]), 200'(1));
      chk("reset_result", i, o_res[i], 200'(0));
    end
    reset = 1'b0;

    // Basic: elements 1..25 times 2
    issue(seq_mat(1, 1), 8'd2);
    measure(1'b0, r0, ov0);
    chk("basic_e0", 0, 200'(r0[7:0]), 200'(8'd2));
    chk("basic_e12", 0, 200'(r0[103:96]), 200'(8'd26));
    chk("basic_e24", 0, 200'(r0[199:192]), 200'(8'd50));
    chk("basic_ovf", 0, 200'(ov0), 200'(0));

    // Overflow: 13*10 and -20*10
    a = seq_mat(1, 0);
    a[7:0]   = 8'd13;
    a[23:16] = 8'hEC;
    issue(a, 8'd10);
    measure(1'b0, r0, ov0);
`ifdef MPU_IMUL_SATURATE_EN
    chk("ovf_13x10", 0, 200'(r0[7:0]), 200'(8'h7F));
    chk("ovf_m20x10", 0, 200'(r0[23:16]), 200'(8'h80));
`else
    chk("ovf_13x10", 0, 200'(r0[7:0]), 200'(8'h82));
    chk("ovf_m20x10", 0, 200'(r0[23:16]), 200'(8'h38));
`endif
    chk("ovf_flag_a", 0, 200'(ov0), 200'(1));

    // Overflow: -128 * -1
    a = seq_mat(1, 0);
    a[7:0] = 8'h80;
    issue(a, 8'hFF);
    measure(1'b0, r0, ov0);
`ifdef MPU_IMUL_SATURATE_EN
    chk("ovf_m128xm1", 0, 200'(r0[7:0]), 200'(8'h7F));
`else
    chk("ovf_m128xm1", 0, 200'(r0[7:0]), 200'(8'h80));
`endif
    chk("ovf_e1", 0, 200'(r0[15:8]), 200'(8'hFF));
    chk("ovf_flag_b", 0, 200'(ov0), 200'(1));

    // Backpressure in DONE with stray cmd_valid pulses
    result_ready = 1'b0;
    issue(seq_mat(-12, 1), 8'hFD);
    for (int c = 0; c < 40; c++) begin
      if (o_rv[0]) break;
      @(negedge clk);
    end
    chk("bp_reach_done", 0, 200'(o_rv[0]), 200'(1));
    cap   = o_res[0];
    capov = o_ovf[0];
    chk("bp_e0", 0, 200'(cap[7:0]), 200'(8'd36));
    chk("bp_e24", 0, 200'(cap[199:192]), 200'(8'hDC));
    for (int c = 0; c < 10; c++) begin
      cmd_valid = ~cmd_valid;
      matrix_a  = rand_mat();
      @(negedge clk);
      chk("bp_hold_result", 0, o_res[0], cap);
      chk("bp_hold_ovf", 0, 200'(o_ovf[0]), 200'(capov));
      chk("bp_hold_valid", 0, 200'(o_rv[0]), 200'(1));
    end
    cmd_valid    = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 0, 200'(o_rv[0]), 200'(0));
    chk("bp_release_ready", 0, 200'(o_ready[0]), 200'(1));

    // Input isolation: inputs scrambled every cycle during RUN
    issue(seq_mat(-12, 1), 8'hF9);
    measure(1'b1, r0, ov0);
    chk("iso_e0", 0, 200'(r0[7:0]), 200'(8'd84));
    chk("iso_e24", 0, 200'(r0[199:192]), 200'(8'hAC));

    // Reset after 10 RUN edges, then a fresh command
    issue(seq_mat(1, 1), 8'd100);
    repeat (10) @(negedge clk);
    chk("pre_reset_ovf", 0, 200'(o_ovf[0]), 200'(1));
    chk("pre_reset_busy", 0, 200'(o_busy[0]), 200'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", 0, 200'(o_ready[0]), 200'(1));
    chk("rst_result", 0, o_res[0], 200'(0));
    chk("rst_ovf", 0, 200'(o_ovf[0]), 200'(0));
    issue(seq_mat(1, 1), 8'd2);
    measure(1'b0, r0, ov0);
    chk("post_rst_e24", 0, 200'(r0[199:192]), 200'(8'd50));
    chk("post_rst_ovf", 0, 200'(ov0), 200'(0));

    // Back-to-back at minimum initiation interval: accepts seen in a 30-cycle window
    matrix_a  = seq_mat(2, 3);
    factor    = 8'd3;
    cmd_valid = 1'b1;
    cnt = '{0, 0, 0};
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NI; i++) cnt[i] += int'(o_ready[i]);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", 0, 200'(cnt[0]), 200'(2));
    chk("b2b_accepts", 1, 200'(cnt[1]), 200'(5));
    chk("b2b_accepts", 2, 200'(cnt[2]), 200'(10));
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
